fighter_ctrl: RTL

Per-frame fighter controller for the footsies game, directly upstream of the raster/draw stage. It samples the player buttons, runs the fighter move/attack state machine once per video frame, and produces the registered fighter X position and attack hitbox. The renderer consumes these outputs to place the 40x40 fighter square and hitbox.

---
 rtl/fighter_pkg.sv | 25 ++
 rtl/fighter_ctrl_btn_sync.sv | 28 ++
 rtl/fighter_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared types and constants for the footsies fighter controller.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK_F   = 3'd1,
    WALK_B   = 3'd2,
    STARTUP  = 3'd3,
    ACTIVE   = 3'd4,
    RECOVERY = 3'd5
  } fighter_state_e;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  // Saturate a signed position to [lo, hi]; callers pass 11-bit signed sums so underflow shows as negative.
  function automatic logic [9:0] clamp_x(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    if (v < lo)      return lo[9:0];
    else if (v > hi) return hi[9:0];
    else             return v[9:0];
  endfunction

endpackage

// File: rtl/fighter_ctrl_btn_sync.sv
// Two-flop synchroniser for one asynchronous button, plus a one-cycle rising-edge pulse.
module btn_sync
  import fighter_pkg::*;
(
  input  logic clk_pix,
  input  logic sim_rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk_pix or negedge sim_rst_n) begin
    if (!sim_rst_n) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      prev_reg <= sync_reg[1];
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/fighter_ctrl.sv
// Per-frame fighter move/attack controller feeding the raster stage.
// Optional FIGHTER_INPUT_BUFFER_EN: a fire press during RECOVERY chains straight into the next STARTUP.
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int X_INIT      = 300,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 600,
  parameter int SQ_W        = 40,
  parameter int WALK_SPD    = 2,
  parameter int STARTUP_FR  = 4,
  parameter int ACTIVE_FR   = 3,
  parameter int RECOVERY_FR = 8,
  parameter int HIT_W       = 24
) (
  input  logic       clk_pix,
  input  logic       sim_rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic [9:0] pos_x,
  output logic       hit_en,
  output logic [9:0] hit_x0,
  output logic [9:0] hit_x1,
  output logic [2:0] fsm_state
);

  localparam int CNT_MAX = (STARTUP_FR > ACTIVE_FR)
                         ? ((STARTUP_FR > RECOVERY_FR) ? STARTUP_FR : RECOVERY_FR)
                         : ((ACTIVE_FR > RECOVERY_FR) ? ACTIVE_FR : RECOVERY_FR);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  // Bit order: 0 = left, 1 = right, 2 = fire.
  logic [2:0] btn_raw, btn_lvl, btn_rise;
  assign btn_raw = {btn_fire, btn_right, btn_left};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      btn_sync u_sync (
        .clk_pix   (clk_pix),
        .sim_rst_n (sim_rst_n),
        .btn       (btn_raw[gi]),
        .level     (btn_lvl[gi]),
        .rise      (btn_rise[gi])
      );
    end
  endgenerate

  logic left_lvl, right_lvl, fire_rise, unused_sync;
  assign left_lvl    = btn_lvl[0];
  assign right_lvl   = btn_lvl[1];
  assign fire_rise   = btn_rise[2];
  assign unused_sync = ^{btn_lvl[2], btn_rise[1:0]};

  fighter_state_e   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [9:0]       pos_reg, pos_next;
  logic             fire_pend_reg, fire_pend_next;
  logic             hit_en_reg;
  logic [9:0]       hit_x0_reg, hit_x1_reg;
  logic             fire_now;
  logic signed [10:0] pos_fwd, pos_back;
`ifdef FIGHTER_INPUT_BUFFER_EN
  logic             buf_fire_reg, buf_fire_next;
`endif

  assign fire_now = fire_pend_reg | fire_rise;
  assign pos_fwd  = $signed({1'b0, pos_reg}) + 11'(WALK_SPD);
  assign pos_back = $signed({1'b0, pos_reg}) - 11'(WALK_SPD);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pos_next       = pos_reg;
    fire_pend_next = fire_pend_reg | fire_rise;
`ifdef FIGHTER_INPUT_BUFFER_EN
    buf_fire_next  = buf_fire_reg | ((state_reg == RECOVERY) & fire_rise);
`endif
    if (frame_tick) begin
      // Pending fire is consumed or discarded at every tick.
      fire_pend_next = 1'b0;
      case (state_reg)
        IDLE, WALK_F, WALK_B: begin
          if (fire_now) begin
            state_next = STARTUP;
            cnt_next   = CNT_W'(STARTUP_FR - 1);
          end else if (right_lvl && !left_lvl) begin
            state_next = WALK_F;
            pos_next   = clamp_x(pos_fwd, 11'(X_MIN), 11'(X_MAX));
          end else if (left_lvl && !right_lvl) begin
            state_next = WALK_B;
            pos_next   = clamp_x(pos_back, 11'(X_MIN), 11'(X_MAX));
          end else begin
            state_next = IDLE;
          end
        end
        STARTUP: begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
          else begin
            state_next = ACTIVE;
            cnt_next   = CNT_W'(ACTIVE_FR - 1);
          end
        end
        ACTIVE: begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
          else begin
            state_next = RECOVERY;
            cnt_next   = CNT_W'(RECOVERY_FR - 1);
          end
        end
        RECOVERY: begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
          else begin
            state_next = IDLE;
`ifdef FIGHTER_INPUT_BUFFER_EN
            if (buf_fire_reg || fire_rise) begin
              state_next = STARTUP;
              cnt_next   = CNT_W'(STARTUP_FR - 1);
            end
            buf_fire_next = 1'b0;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge sim_rst_n) begin
    if (!sim_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pos_reg       <= 10'(X_INIT);
      fire_pend_reg <= 1'b0;
      hit_en_reg    <= 1'b0;
      hit_x0_reg    <= 10'(X_INIT + SQ_W);
      hit_x1_reg    <= 10'(X_INIT + SQ_W + HIT_W);
`ifdef FIGHTER_INPUT_BUFFER_EN
      buf_fire_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pos_reg       <= pos_next;
      fire_pend_reg <= fire_pend_next;
      hit_en_reg    <= (state_next == ACTIVE);
      hit_x0_reg    <= pos_next + 10'(SQ_W);
      hit_x1_reg    <= pos_next + 10'(SQ_W + HIT_W);
`ifdef FIGHTER_INPUT_BUFFER_EN
      buf_fire_reg  <= buf_fire_next;
`endif
    end
  end

  assign pos_x     = pos_reg;
  assign hit_en    = hit_en_reg;
  assign hit_x0    = hit_x0_reg;
  assign hit_x1    = hit_x1_reg;
  assign fsm_state = state_reg;

endmodule
